// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared op codes, FSM state encoding and op decode helpers
// for the execute-stage HI/LO multiply/divide sequencer.
package hilo_muldiv_ctrl_pkg;

    typedef logic [1:0] md_op_t;

    localparam md_op_t MD_MULT  = 2'b00;
    localparam md_op_t MD_MULTU = 2'b01;
    localparam md_op_t MD_DIV   = 2'b10;
    localparam md_op_t MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    function automatic logic op_is_div(md_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(md_op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// E-stage request / HI/LO write-port bundle between the
// pipeline (master) and the mul/div sequencer (slave).
interface hilo_muldiv_ctrl_if
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             flushE;
    logic             startE;
    md_op_t           opE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             stall_o;
    logic             hilo_we_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output flushE, startE, opE, srcaE, srcbE,
        input  stall_o, hilo_we_o, hi_o, lo_o
    );

    modport slave (
        input  flushE, startE, opE, srcaE, srcbE,
        output stall_o, hilo_we_o, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_ctrl_div_step.sv
// One restoring-division step on unsigned magnitudes:
// shift {rem,quo} left, subtract divisor if it fits.
module hilo_muldiv_ctrl_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;

    // rem_i < div_i, so the shifted partial remainder fits WIDTH+1 bits
    assign sh    = {rem_i, quo_i[WIDTH-1]};
    assign diff  = sh - {1'b0, div_i};
    assign rem_o = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// Execute-stage MULT/MULTU/DIV/DIVU sequencer owning the HI/LO
// write port; stalls F/D/E while busy, then pulses one write.
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    hilo_muldiv_ctrl_if.slave  md
);
    localparam int CW = $clog2(WIDTH);

    md_state_e        state_q, state_d;
    md_op_t           op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic               sgn;
    logic               q_neg;
    logic               r_neg;
    logic [WIDTH-1:0]   dmag;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quo_nx;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;

    assign sgn   = op_is_signed(op_q);
    assign q_neg = sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    assign r_neg = sgn & a_q[WIDTH-1];
    assign dmag  = (sgn & b_q[WIDTH-1]) ? -b_q : b_q;

    // low 2W bits of the extended product are the signed/unsigned result
    assign ext_a = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    assign ext_b = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    assign prod  = ext_a * ext_b;

    hilo_muldiv_ctrl_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dmag),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        if (md.flushE) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (md.startE) begin
                        op_d = md.opE;
                        a_d  = md.srcaE;
                        b_d  = md.srcbE;
                        if (!op_is_div(md.opE)) begin
                            state_d = ST_MUL;
                        end else if (md.srcbE == '0) begin
                            state_d = ST_DONE;
                            hi_d    = md.srcaE;
                            lo_d    = '1;
                        end else begin
                            state_d = ST_DIV;
                            cnt_d   = '0;
                            rem_d   = '0;
                            quo_d   = (op_is_signed(md.opE) &&
                                       md.srcaE[WIDTH-1])
                                      ? -md.srcaE : md.srcaE;
                        end
                    end
                end
                ST_MUL: begin
                    {hi_d, lo_d} = prod;
                    state_d      = ST_DONE;
                end
                ST_DIV: begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        hi_d    = r_neg ? -rem_nx : rem_nx;
                        lo_d    = q_neg ? -quo_nx : quo_nx;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md.stall_o = ~rst & ~md.flushE &
                        ((state_q == ST_IDLE && md.startE) ||
                         state_q == ST_MUL ||
                         state_q == ST_DIV);
    assign md.hilo_we_o = ~rst & ~md.flushE &
                          (state_q == ST_DONE);
    assign md.hi_o = hi_q;
    assign md.lo_o = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: arithmetic reference model
// predicts stall length and HI/LO; one negedge process compares.
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hilo_muldiv_ctrl_if #(.WIDTH(W)) md();

    hilo_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .md  (md)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bit         ck = 1'b0;
    bit         es = 1'b0;
    bit         ew = 1'b0;
    bit         hc = 1'b0;
    logic [W-1:0] eh = '0;
    logic [W-1:0] el = '0;

    task automatic check(input string nm, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act,
                          input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward
    // zero, matching the quotient/remainder sign rules.
    function automatic void model(input md_op_t op,
                                  input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output int lat,
                                  output logic [W-1:0] hi,
                                  output logic [W-1:0] lo);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        hi = '0;
        lo = '0;
        lat = 0;
        if (op == MD_MULT || op == MD_MULTU) begin
            p   = (op == MD_MULT) ? longint'(sa * sb) : ua * ub;
            hi  = p[63:32];
            lo  = p[31:0];
            lat = 2;
        end else if (b == '0) begin
            hi  = a;
            lo  = '1;
            lat = 1;
        end else begin
            if (op == MD_DIV) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
            end
            hi  = r[31:0];
            lo  = q[31:0];
            lat = W + 1;
        end
    endfunction

    always @(negedge clk) begin
        if (ck) begin
            check1("stall_o", md.stall_o, es);
            check1("hilo_we_o", md.hilo_we_o, ew);
            if (hc) begin
                check("hi_o", md.hi_o, eh);
                check("lo_o", md.lo_o, el);
            end
        end
    end

    task automatic cyc(input bit r, input bit fl, input bit st,
                       input md_op_t op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit c, input bit s, input bit w,
                       input bit h,
                       input logic [W-1:0] xh,
                       input logic [W-1:0] xl);
        @(posedge clk);
        #1;
        rst       = r;
        md.flushE = fl;
        md.startE = st;
        md.opE    = op;
        md.srcaE  = a;
        md.srcbE  = b;
        ck = c;
        es = s;
        ew = w;
        hc = h;
        eh = xh;
        el = xl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, MD_MULT, '0, '0, 1, 0, 0, 0, '0, '0);
    endtask

    // kill_at: cycle index (0 = start cycle) where flush or rst hits
    task automatic op_run(input md_op_t op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int kill_at,
                          input bit kill_rst);
        int lat;
        logic [W-1:0] h, l, ra, rb;
        model(op, a, b, lat, h, l);
        for (int i = 0; i <= lat; i++) begin
            ra = (i == 0) ? a : W'($urandom);
            rb = (i == 0) ? b : W'($urandom);
            if (i == kill_at) begin
                if (kill_rst)
                    cyc(1, 0, 1, op, ra, rb, 0, 0, 0, 0, '0, '0);
                else
                    cyc(0, 1, 1, op, ra, rb, 1, 0, 0, 0, '0, '0);
                cyc(0, 0, 0, op, '0, '0, 1, 0, 0, kill_rst, '0, '0);
                return;
            end
            if (i < lat)
                cyc(0, 0, 1, op, ra, rb, 1, 1, 0, 0, '0, '0);
            else
                cyc(0, 0, 1, op, ra, rb, 1, 0, 1, 1, h, l);
        end
    endtask

    initial begin
        int lat;
        logic [W-1:0] h, l;

        model(MD_MULT, 32'hFFFF_FFFE, 32'h3, lat, h, l);
        check("pin_mult_hi", h, 32'hFFFF_FFFF);
        check("pin_mult_lo", l, 32'hFFFF_FFFA);
        check("pin_mult_lat", W'(lat), 32'd2);
        model(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, h, l);
        check("pin_multu_hi", h, 32'hFFFF_FFFE);
        check("pin_multu_lo", l, 32'h0000_0001);
        model(MD_DIV, 32'hFFFF_FFF9, 32'h2, lat, h, l);
        check("pin_div_hi", h, 32'hFFFF_FFFF);
        check("pin_div_lo", l, 32'hFFFF_FFFD);
        check("pin_div_lat", W'(lat), 32'd33);
        model(MD_DIVU, 32'd100, 32'd7, lat, h, l);
        check("pin_divu_hi", h, 32'd2);
        check("pin_divu_lo", l, 32'd14);
        model(MD_DIVU, 32'd5, 32'd0, lat, h, l);
        check("pin_div0_hi", h, 32'd5);
        check("pin_div0_lo", l, 32'hFFFF_FFFF);
        check("pin_div0_lat", W'(lat), 32'd1);
        model(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l);
        check("pin_ovf_hi", h, 32'h0);
        check("pin_ovf_lo", l, 32'h8000_0000);

        md.flushE = 1'b0;
        md.startE = 1'b0;
        md.opE    = MD_MULT;
        md.srcaE  = '0;
        md.srcbE  = '0;
        cyc(1, 0, 0, MD_MULT, '0, '0, 0, 0, 0, 0, '0, '0);
        cyc(1, 0, 0, MD_MULT, '0, '0, 0, 0, 0, 0, '0, '0);
        cyc(0, 0, 0, MD_MULT, '0, '0, 1, 0, 0, 1, '0, '0);
        idle(1);

        op_run(MD_MULT, 32'hFFFF_FFFE, 32'h3, -1, 0);
        idle(2);
        op_run(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 0);
        idle(1);
        op_run(MD_DIV, 32'hFFFF_FFF9, 32'h2, -1, 0);
        idle(1);
        op_run(MD_DIVU, 32'd100, 32'd7, -1, 0);
        idle(1);
        op_run(MD_DIVU, 32'd5, 32'd0, -1, 0);
        idle(1);
        op_run(MD_DIV, 32'hFFFF_FFF0, 32'd0, -1, 0);
        idle(1);
        op_run(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        idle(1);
        op_run(MD_DIV, 32'd7, 32'hFFFF_FFFE, -1, 0);
        op_run(MD_DIVU, 32'hFFFF_FFFF, 32'd1, -1, 0);
        op_run(MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0);
        op_run(MD_MULT, 32'h8000_0000, 32'h8000_0000, -1, 0);
        op_run(MD_MULT, 32'h1234_5678, 32'hFEDC_BA98, -1, 0);
        idle(2);

        op_run(MD_DIV, 32'd1000, 32'd7, 11, 0);
        idle(3);
        op_run(MD_DIVU, 32'd100, 32'd7, -1, 0);
        op_run(MD_MULT, 32'd5, 32'd6, 1, 0);
        idle(2);
        op_run(MD_MULTU, 32'd5, 32'd6, 2, 0);
        idle(2);
        op_run(MD_DIV, 32'd9, 32'd2, 0, 0);
        idle(2);
        op_run(MD_DIV, 32'hFFFF_FF9C, 32'd9, -1, 0);

        op_run(MD_DIV, 32'd12345, 32'd67, 15, 1);
        idle(2);
        op_run(MD_MULT, 32'd7, 32'd8, 2, 1);
        idle(2);

        op_run(MD_MULT, 32'hFFFF_FFFD, 32'd11, -1, 0);
        op_run(MD_DIV, 32'hFFFF_FF85, 32'hFFFF_FFF6, -1, 0);
        idle(3);

        ck = 1'b0;
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
